// File: rtl/coh_bus_arbiter.sv
// Snooping-bus arbiter and coherence sequencer for NCPU cores.
// Optional memory-fill timeout: define COH_TIMEOUT_EN.
module coh_bus_arbiter #(
  parameter int NCPU        = 2,
  parameter int ADDR_W      = 11,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCPU-1:0]          read_miss,
  input  logic [NCPU-1:0]          write_miss,
  input  logic [NCPU-1:0]          invalidate,
  input  logic [NCPU*ADDR_W-1:0]   BICO,
  input  logic [NCPU-1:0]          cpu_search_found,
  input  logic                     u_rdy,
  output logic [NCPU-1:0]          grant,
  output logic [NCPU-1:0]          cpu_search,
  output logic [ADDR_W+1:0]        BOCI,
  output logic [2*NCPU-1:0]        cpu_datasel,
  output logic [NCPU-1:0]          invalidate_from_other_cpu,
  output logic                     u_re,
  output logic                     busy,
  output logic                     bus_err
);

  localparam int IW = (NCPU > 1) ? $clog2(NCPU) : 1;

  localparam logic [1:0] T_RD  = 2'b01;
  localparam logic [1:0] T_WR  = 2'b10;
  localparam logic [1:0] T_INV = 2'b11;

  localparam logic [1:0] D_NONE = 2'b00;
  localparam logic [1:0] D_MEM  = 2'b01;
  localparam logic [1:0] D_PEER = 2'b10;
  localparam logic [1:0] D_SUP  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNOOP,
    S_DECIDE,
    S_INVAL,
    S_XFER,
    S_MEM,
    S_GRANT
  } state_t;

  state_t              state, nxt;
  logic [IW-1:0]       rr, win, sup;
  logic [1:0]          typ;
  logic [ADDR_W-1:0]   addr;
  logic                hit;
  logic [1:0]          src;

  logic [NCPU-1:0]     req;
  logic [IW-1:0]       pick, cand;
  logic                pick_vld;
  logic [1:0]          ptype;
  logic [ADDR_W-1:0]   paddr;
  logic [NCPU-1:0]     win_oh;
  logic [NCPU-1:0]     hits;
  logic [IW-1:0]       sup_c;
  logic                tmo;

`ifdef COH_TIMEOUT_EN
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  logic [CW-1:0]       cnt;
  logic                err_q;
`endif

  // Round-robin pick: first requester at or above rr, wrapping.
  always_comb begin
    req      = read_miss | write_miss | invalidate;
    pick     = '0;
    cand     = '0;
    pick_vld = 1'b0;
    for (int k = NCPU - 1; k >= 0; k--) begin
      cand = IW'((int'(rr) + k) % NCPU);
      if (req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // Winner's request type and address slice.
  always_comb begin
    ptype = T_RD;
    paddr = '0;
    if (invalidate[pick])
      ptype = T_INV;
    else if (write_miss[pick])
      ptype = T_WR;
    for (int i = 0; i < NCPU; i++)
      if (pick == IW'(i))
        paddr = BICO[i*ADDR_W +: ADDR_W];
  end

  // Peer snoop hits; the winner's own hit is ignored.
  always_comb begin
    win_oh = NCPU'(1) << win;
    hits   = cpu_search_found & ~win_oh;
    sup_c  = '0;
    for (int i = NCPU - 1; i >= 0; i--)
      if (hits[i])
        sup_c = IW'(i);
  end

`ifdef COH_TIMEOUT_EN
  // Fill abandoned once MEM has lasted MEM_TIMEOUT cycles.
  always_comb begin
    tmo = (state == S_MEM) && !u_rdy &&
          (cnt == CW'(MEM_TIMEOUT - 1));
  end
`else
  // No timeout: MEM waits for u_rdy indefinitely.
  always_comb begin
    tmo = 1'b0;
  end
`endif

  // Next-state decode.
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (pick_vld) nxt = S_SNOOP;
      S_SNOOP:  nxt = S_DECIDE;
      S_DECIDE: begin
        if (typ != T_RD)  nxt = S_INVAL;
        else if (|hits)   nxt = S_XFER;
        else              nxt = S_MEM;
      end
      S_INVAL: begin
        if (typ == T_INV) nxt = S_GRANT;
        else if (hit)     nxt = S_XFER;
        else              nxt = S_MEM;
      end
      S_XFER:   nxt = S_GRANT;
      S_MEM:    if (u_rdy || tmo) nxt = S_GRANT;
      S_GRANT:  nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // State and transaction context registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      rr    <= '0;
      win   <= '0;
      typ   <= '0;
      addr  <= '0;
      sup   <= '0;
      hit   <= 1'b0;
      src   <= D_NONE;
    end else begin
      state <= nxt;
      if (state == S_IDLE && pick_vld) begin
        win  <= pick;
        typ  <= ptype;
        addr <= paddr;
        rr   <= (pick == IW'(NCPU - 1)) ? '0 : pick + 1'b1;
        hit  <= 1'b0;
        src  <= D_NONE;
      end
      if (state == S_DECIDE) begin
        hit <= |hits;
        sup <= sup_c;
      end
      if (nxt == S_XFER)
        src <= D_PEER;
      if (nxt == S_MEM && state != S_MEM)
        src <= D_MEM;
      if (tmo)
        src <= D_NONE;
    end
  end

`ifdef COH_TIMEOUT_EN
  // MEM cycle counter and one-cycle error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      cnt   <= (state == S_MEM) ? cnt + 1'b1 : '0;
      err_q <= tmo;
    end
  end

  assign bus_err = err_q;
`else
  assign bus_err = 1'b0;
`endif

  // Moore output decode.
  always_comb begin
    grant                     = '0;
    cpu_search                = '0;
    invalidate_from_other_cpu = '0;
    u_re                      = 1'b0;
    cpu_datasel               = '0;
    busy                      = (state != S_IDLE);
    BOCI                      = busy ? {typ, addr} : '0;
    unique case (state)
      S_SNOOP: cpu_search = ~win_oh;
      S_INVAL: invalidate_from_other_cpu = ~win_oh;
      S_MEM:   u_re = 1'b1;
      S_GRANT: grant = win_oh;
      default: ;
    endcase
    if (state == S_XFER || state == S_MEM || state == S_GRANT) begin
      for (int i = 0; i < NCPU; i++) begin
        if (src == D_PEER && sup == IW'(i))
          cpu_datasel[2*i +: 2] = D_SUP;
        if (win == IW'(i))
          cpu_datasel[2*i +: 2] = src;
      end
    end
  end

endmodule

// File: tb/tb_coh_bus_arbiter.sv
// Directed bench for coh_bus_arbiter, NCPU=4.
// Table of single transactions plus reset, round-robin, timeout cases.
module tb_coh_bus_arbiter;

  localparam int NCPU = 4;
  localparam int AW   = 11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        read_miss, write_miss, invalidate;
  logic [4*AW-1:0]   BICO;
  logic [3:0]        cpu_search_found;
  logic              u_rdy;
  logic [3:0]        grant, cpu_search, invalidate_from_other_cpu;
  logic [AW+1:0]     BOCI;
  logic [7:0]        cpu_datasel;
  logic              u_re, busy, bus_err;

  int ntests = 0;
  int nfail  = 0;

  coh_bus_arbiter #(
    .NCPU(NCPU), .ADDR_W(AW), .MEM_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .read_miss(read_miss), .write_miss(write_miss),
    .invalidate(invalidate), .BICO(BICO),
    .cpu_search_found(cpu_search_found), .u_rdy(u_rdy),
    .grant(grant), .cpu_search(cpu_search), .BOCI(BOCI),
    .cpu_datasel(cpu_datasel),
    .invalidate_from_other_cpu(invalidate_from_other_cpu),
    .u_re(u_re), .busy(busy), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rm, wm, inv, fnd;
    logic [10:0] addr;
    int          mem_lat;
    int          lat;
    logic [12:0] boci;
    logic [3:0]  srch, invs;
    int          ure;
    logic [7:0]  dsel;
    logic [3:0]  gnt;
  } vec_t;

  typedef struct {
    int          got, lat, ure, berr, berr_g;
    logic [12:0] boci;
    logic [3:0]  srch, invs, gnt;
    logic [7:0]  dsel;
  } obs_t;

  vec_t vecs[7];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_in();
    read_miss        = '0;
    write_miss       = '0;
    invalidate       = '0;
    cpu_search_found = '0;
    u_rdy            = 1'b0;
  endtask

  // Issue one transaction from IDLE and observe it until grant.
  task automatic run(input vec_t v, input int maxc, output obs_t o);
    int n;
    int ucnt;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    o = '{default: 0};
    ucnt = 0;
    read_miss        = v.rm;
    write_miss       = v.wm;
    invalidate       = v.inv;
    cpu_search_found = v.fnd;
    for (int i = 0; i < 4; i++)
      BICO[i*AW +: AW] = v.addr + 11'(i);
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      if (c == 1) begin
        o.boci = BOCI;
        o.srch = cpu_search;
      end
      o.invs |= invalidate_from_other_cpu;
      if (bus_err) o.berr++;
      if (u_re) begin
        ucnt++;
        o.ure++;
      end
      u_rdy = u_re && (ucnt == v.mem_lat);
      if (|grant) begin
        o.got    = 1;
        o.lat    = c;
        o.gnt    = grant;
        o.dsel   = cpu_datasel;
        o.berr_g = int'(bus_err);
        read_miss        = read_miss & ~grant;
        write_miss       = write_miss & ~grant;
        invalidate       = invalidate & ~grant;
        cpu_search_found = '0;
        u_rdy            = 1'b0;
        break;
      end
    end
  endtask

  task automatic chk_idle(string nm);
    chk({nm, "_outs"},
        {grant, cpu_search, cpu_datasel,
         invalidate_from_other_cpu, u_re, busy, bus_err}, 0);
    chk({nm, "_boci"}, BOCI, 0);
  endtask

  initial begin
    obs_t o;
    vec_t v;
    int   gseen;
    int   n;

    // rm wm inv fnd addr memlat lat boci srch invs ure dsel gnt
    vecs[0] = '{4'b0001, 4'b0000, 4'b0000, 4'b0100, 11'h155,
                0, 4, 13'h0955, 4'b1110, 4'b0000, 0, 8'h32, 4'b0001};
    vecs[1] = '{4'b0000, 4'b0010, 4'b0000, 4'b0010, 11'h2A0,
                5, 9, 13'h12A1, 4'b1101, 4'b1101, 5, 8'h04, 4'b0010};
    vecs[2] = '{4'b0001, 4'b0000, 4'b0001, 4'b0010, 11'h7FF,
                0, 4, 13'h1FFF, 4'b1110, 4'b1110, 0, 8'h00, 4'b0001};
    vecs[3] = '{4'b1000, 4'b0000, 4'b0000, 4'b1000, 11'h000,
                1, 4, 13'h0803, 4'b0111, 4'b0000, 1, 8'h40, 4'b1000};
    vecs[4] = '{4'b0000, 4'b0100, 4'b0000, 4'b1011, 11'h100,
                0, 5, 13'h1102, 4'b1011, 4'b1011, 0, 8'h23, 4'b0100};
    vecs[5] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 11'h400,
                2, 6, 13'h1401, 4'b1101, 4'b1101, 2, 8'h04, 4'b0010};
    vecs[6] = '{4'b1000, 4'b0000, 4'b0000, 4'b0110, 11'h0F0,
                0, 4, 13'h08F3, 4'b0111, 4'b0000, 0, 8'h8C, 4'b1000};

    rst_n = 1'b0;
    BICO  = '0;
    clear_in();
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");

    foreach (vecs[i]) begin
      run(vecs[i], 40, o);
      chk($sformatf("v%0d_got", i),  o.got,  1);
      chk($sformatf("v%0d_lat", i),  o.lat,  vecs[i].lat);
      chk($sformatf("v%0d_gnt", i),  o.gnt,  vecs[i].gnt);
      chk($sformatf("v%0d_boci", i), o.boci, vecs[i].boci);
      chk($sformatf("v%0d_srch", i), o.srch, vecs[i].srch);
      chk($sformatf("v%0d_invs", i), o.invs, vecs[i].invs);
      chk($sformatf("v%0d_ure", i),  o.ure,  vecs[i].ure);
      chk($sformatf("v%0d_dsel", i), o.dsel, vecs[i].dsel);
      chk($sformatf("v%0d_berr", i), o.berr, 0);
    end

    // Reset in the middle of a memory fill.
    @(negedge clk);
    read_miss = 4'b0001;
    n = 0;
    while (!u_re && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("midmem_ure", u_re, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    clear_in();
    #1;
    chk_idle("midmem_rst");
    gseen = 0;
    repeat (3) begin
      @(negedge clk);
      if (|grant) gseen++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (|grant || busy) gseen++;
    end
    chk("midmem_nogrant", gseen, 0);

    // rr must be 0 after reset: core0 beats core3.
    v = vecs[0];
    v.rm = 4'b1001;
    run(v, 20, o);
    chk("rr_rst_gnt", o.gnt, 4'b0001);
    v.rm = 4'b1000;
    run(v, 20, o);
    chk("rr_drain_gnt", o.gnt, 4'b1000);

    // Cores 1 and 3 together: core1 then core3.
    v.rm = 4'b1010;
    run(v, 20, o);
    chk("rr_a_gnt", o.gnt, 4'b0010);
    chk("rr_a_lat", o.lat, 4);
    v.rm = 4'b1000;
    run(v, 20, o);
    chk("rr_b_gnt", o.gnt, 4'b1000);
    chk("rr_b_lat", o.lat, 4);
    v.rm = 4'b1001;
    run(v, 20, o);
    chk("rr_wrap_gnt", o.gnt, 4'b0001);
    v.rm = 4'b1000;
    run(v, 20, o);
    chk("rr_wrap2_gnt", o.gnt, 4'b1000);

    // Memory fill that never completes.
    v = vecs[0];
    v.rm      = 4'b0010;
    v.fnd     = 4'b0000;
    v.mem_lat = 0;
`ifdef COH_TIMEOUT_EN
    run(v, 30, o);
    chk("tmo_got",   o.got,    1);
    chk("tmo_lat",   o.lat,    11);
    chk("tmo_gnt",   o.gnt,    4'b0010);
    chk("tmo_ure",   o.ure,    8);
    chk("tmo_dsel",  o.dsel,   8'h00);
    chk("tmo_berr",  o.berr,   1);
    chk("tmo_berrg", o.berr_g, 1);
`else
    run(v, 20, o);
    chk("hang_got",  o.got,  0);
    chk("hang_ure",  o.ure,  18);
    chk("hang_berr", o.berr, 0);
    chk("hang_dsel", cpu_datasel, 8'h04);
    rst_n = 1'b0;
    clear_in();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("hang_rst");
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
